// File: rtl/i2c_target_rx.sv
// I2C write-only target: receives bytes addressed to ADDR, ACKs each one.
// Define I2C_TARGET_GLITCH_FILTER_EN to add a 3-sample majority filter.
module i2c_target_rx #(
  parameter logic [6:0] ADDR = 7'h20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i2c_scl,
  input  logic       i2c_sda_in,
  output logic       i2c_sda_oe,
  output logic [7:0] data,
  output logic       valid,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_DATA,
    S_DATA_ACK,
    S_IGNORE
  } state_e;

  logic scl_s1_q, scl_s2_q;
  logic sda_s1_q, sda_s2_q;
  logic scl_f, sda_f;
  logic scl_p_q, sda_p_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_s1_q <= 1'b1;
      scl_s2_q <= 1'b1;
      sda_s1_q <= 1'b1;
      sda_s2_q <= 1'b1;
    end else begin
      scl_s1_q <= i2c_scl;
      scl_s2_q <= scl_s1_q;
      sda_s1_q <= i2c_sda_in;
      sda_s2_q <= sda_s1_q;
    end
  end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
  logic [2:0] scl_h_q, sda_h_q;
  logic       scl_m_q, sda_m_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_h_q <= 3'b111;
      sda_h_q <= 3'b111;
      scl_m_q <= 1'b1;
      sda_m_q <= 1'b1;
    end else begin
      scl_h_q <= {scl_h_q[1:0], scl_s2_q};
      sda_h_q <= {sda_h_q[1:0], sda_s2_q};
      scl_m_q <= (scl_h_q[0] & scl_h_q[1]) |
                 (scl_h_q[0] & scl_h_q[2]) |
                 (scl_h_q[1] & scl_h_q[2]);
      sda_m_q <= (sda_h_q[0] & sda_h_q[1]) |
                 (sda_h_q[0] & sda_h_q[2]) |
                 (sda_h_q[1] & sda_h_q[2]);
    end
  end

  assign scl_f = scl_m_q;
  assign sda_f = sda_m_q;
`else
  assign scl_f = scl_s2_q;
  assign sda_f = sda_s2_q;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scl_p_q <= 1'b1;
      sda_p_q <= 1'b1;
    end else begin
      scl_p_q <= scl_f;
      sda_p_q <= sda_f;
    end
  end

  logic start, stop, scl_rise, scl_fall;

  assign start    = scl_f & scl_p_q & sda_p_q & ~sda_f;
  assign stop     = scl_f & scl_p_q & ~sda_p_q & sda_f;
  assign scl_rise = scl_f & ~scl_p_q;
  assign scl_fall = ~scl_f & scl_p_q;

  state_e     state_q;
  logic [2:0] cnt_q;
  logic [7:0] shift_q;
  logic [7:0] data_q;
  logic [7:0] byte_d;
  logic       ack_q;
  logic       oe_q;
  logic       valid_q;
  logic       busy_q;

  assign byte_d = {shift_q[6:0], sda_f};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
      shift_q <= 8'h00;
      data_q  <= 8'h00;
      ack_q   <= 1'b0;
      oe_q    <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (start) begin
        state_q <= S_ADDR;
        cnt_q   <= 3'd0;
        shift_q <= 8'h00;
        ack_q   <= 1'b0;
        oe_q    <= 1'b0;
        busy_q  <= 1'b0;
      end else if (stop) begin
        state_q <= S_IDLE;
        cnt_q   <= 3'd0;
        ack_q   <= 1'b0;
        oe_q    <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        unique case (state_q)
          S_ADDR: begin
            if (scl_rise) begin
              shift_q <= byte_d;
              cnt_q   <= cnt_q + 3'd1;
              if (cnt_q == 3'd7) begin
                ack_q <= 1'b0;
                if (byte_d == {ADDR, 1'b0}) begin
                  state_q <= S_ADDR_ACK;
                  busy_q  <= 1'b1;
                end else begin
                  state_q <= S_IGNORE;
                end
              end
            end
          end
          S_DATA: begin
            if (scl_rise) begin
              shift_q <= byte_d;
              cnt_q   <= cnt_q + 3'd1;
              if (cnt_q == 3'd7) begin
                state_q <= S_DATA_ACK;
                ack_q   <= 1'b0;
              end
            end
          end
          S_ADDR_ACK, S_DATA_ACK: begin
            // first fall drives ACK, second fall ends the 9th pulse
            if (scl_fall) begin
              if (!ack_q) begin
                ack_q <= 1'b1;
                oe_q  <= 1'b1;
                if (state_q == S_DATA_ACK) begin
                  data_q  <= shift_q;
                  valid_q <= 1'b1;
                end
              end else begin
                ack_q   <= 1'b0;
                oe_q    <= 1'b0;
                cnt_q   <= 3'd0;
                state_q <= S_DATA;
              end
            end
          end
          default: begin
            oe_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign i2c_sda_oe = oe_q;
  assign data       = data_q;
  assign valid      = valid_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_i2c_target_rx.sv
// Bench for i2c_target_rx: table vectors, hand sequences and
// randomized transfers against a transaction-level model.
module tb_i2c_target_rx;

  localparam int Q = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       scl = 1'b1;
  logic       m_sda = 1'b1;
  logic       sda_in;
  logic       oe;
  logic [7:0] data;
  logic       valid;
  logic       busy;

  assign sda_in = m_sda & ~oe;

  always #5 clk = ~clk;

  i2c_target_rx #(.ADDR(7'h20)) dut (
    .clk        (clk),
    .reset      (reset),
    .i2c_scl    (scl),
    .i2c_sda_in (sda_in),
    .i2c_sda_oe (oe),
    .data       (data),
    .valid      (valid),
    .busy       (busy)
  );

  int n_tests = 0;
  int n_fail = 0;
  int valid_cnt = 0;
  int oe_cnt = 0;

  always @(posedge clk) begin
    if (valid === 1'b1) valid_cnt++;
    if (oe === 1'b1) oe_cnt++;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; tick(Q);
    scl = 1'b1;   tick(Q);
    m_sda = 1'b0; tick(Q);
    scl = 1'b0;   tick(Q);
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; tick(Q);
    scl = 1'b1;   tick(Q);
    m_sda = 1'b1; tick(Q);
  endtask

  task automatic send_bit(input logic b, input logic glitch);
    m_sda = b; tick(Q);
    scl = 1'b1; tick(Q);
    if (glitch) begin
      scl = 1'b0; tick(1);
      scl = 1'b1; tick(Q - 1);
    end else begin
      tick(Q);
    end
    scl = 1'b0; tick(Q);
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i], 1'b0);
  endtask

  task automatic ack_bit(output logic a, output logic bz);
    m_sda = 1'b1; tick(Q);
    scl = 1'b1;   tick(Q);
    a = ~sda_in;
    bz = busy;
    tick(Q);
    scl = 1'b0;   tick(Q);
  endtask

  task automatic txn(input logic [7:0] ab, input int n,
                     input logic [31:0] bs, output int acks,
                     output logic bz_mid);
    logic a, bz;
    acks = 0;
    i2c_start();
    send_byte(ab);
    ack_bit(a, bz_mid);
    acks += int'(a);
    for (int i = 0; i < n; i++) begin
      send_byte(bs[31 - 8 * i -: 8]);
      ack_bit(a, bz);
      acks += int'(a);
    end
    i2c_stop();
    tick(4);
  endtask

  typedef struct {
    logic [7:0]  ab;
    int          n;
    logic [31:0] bs;
    int          e_acks;
    int          e_valid;
    logic [7:0]  e_data;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int          acks, v0, o0;
    logic        bzm, a, bz;
    logic [7:0]  ab, m_data, last;
    logic [31:0] bs;
    int          n;
    logic        hit;

    tbl[0] = '{8'h40, 1, 32'hBB000000, 2, 1, 8'hBB};
    tbl[1] = '{8'h42, 1, 32'hBB000000, 0, 0, 8'hBB};
    tbl[2] = '{8'h40, 2, 32'hBBAB0000, 3, 2, 8'hAB};
    tbl[3] = '{8'h41, 1, 32'h55000000, 0, 0, 8'hAB};
    tbl[4] = '{8'h40, 1, 32'h00000000, 2, 1, 8'h00};
    tbl[5] = '{8'h40, 3, 32'hFF018000, 4, 3, 8'h80};

    tick(3);
    chk("rst_oe", oe, 0);
    chk("rst_data", data, 0);
    chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b1;
    tick(4);

    for (int i = 0; i < 6; i++) begin
      v0 = valid_cnt;
      o0 = oe_cnt;
      txn(tbl[i].ab, tbl[i].n, tbl[i].bs, acks, bzm);
      chk($sformatf("v%0d_acks", i), acks, tbl[i].e_acks);
      chk($sformatf("v%0d_valid", i), valid_cnt - v0, tbl[i].e_valid);
      chk($sformatf("v%0d_data", i), data, tbl[i].e_data);
      chk($sformatf("v%0d_busy_mid", i), bzm, tbl[i].e_acks > 0);
      chk($sformatf("v%0d_busy_end", i), busy, 0);
      chk($sformatf("v%0d_oe_seen", i), oe_cnt > o0, tbl[i].e_acks > 0);
    end

    // partial byte cut short by a repeated START
    v0 = valid_cnt;
    i2c_start();
    send_byte(8'h40);
    ack_bit(a, bz);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    i2c_start();
    chk("rs_busy_clr", busy, 0);
    chk("rs_no_valid", valid_cnt - v0, 0);
    send_byte(8'h40);
    ack_bit(a, bz);
    chk("rs_addr_ack", a, 1);
    send_byte(8'hAB);
    ack_bit(a, bz);
    chk("rs_data_ack", a, 1);
    i2c_stop();
    tick(4);
    chk("rs_valid", valid_cnt - v0, 1);
    chk("rs_data", data, 8'hAB);

    // reset asserted while the target drives the data ACK
    i2c_start();
    send_byte(8'h40);
    ack_bit(a, bz);
    send_byte(8'hBB);
    m_sda = 1'b1; tick(Q);
    scl = 1'b1;   tick(Q);
    chk("ra_oe_before", oe, 1);
    reset = 1'b0;
    #1;
    chk("ra_oe_async", oe, 0);
    chk("ra_data", data, 0);
    chk("ra_busy", busy, 0);
    chk("ra_valid", valid, 0);
    tick(4);
    reset = 1'b1;
    tick(4);
    v0 = valid_cnt;
    txn(8'h40, 1, 32'hAB000000, acks, bzm);
    chk("ra_post_acks", acks, 2);
    chk("ra_post_valid", valid_cnt - v0, 1);
    chk("ra_post_data", data, 8'hAB);

    // randomized transfers against a transaction-level model
    m_data = 8'hAB;
    for (int t = 0; t < 16; t++) begin
      ab = ($urandom % 2 == 0) ? 8'h40 : 8'($urandom);
      n = int'($urandom_range(1, 3));
      bs = $urandom;
      hit = (ab[7:1] == 7'h20) && (ab[0] == 1'b0);
      last = bs[31 - 8 * (n - 1) -: 8];
      if (hit) m_data = last;
      v0 = valid_cnt;
      txn(ab, n, bs, acks, bzm);
      chk($sformatf("r%0d_acks", t), acks, hit ? n + 1 : 0);
      chk($sformatf("r%0d_valid", t), valid_cnt - v0, hit ? n : 0);
      chk($sformatf("r%0d_data", t), data, m_data);
      chk($sformatf("r%0d_busy", t), busy, 0);
    end

    // 1-clk SCL glitch in the high phase of the first data bit
    v0 = valid_cnt;
    i2c_start();
    send_byte(8'h40);
    ack_bit(a, bz);
    send_bit(1'b1, 1'b1);
    for (int i = 6; i >= 0; i--) send_bit(8'hBB >> i, 1'b0);
    ack_bit(a, bz);
    i2c_stop();
    tick(4);
    chk("gl_valid", valid_cnt - v0, 1);
`ifdef I2C_TARGET_GLITCH_FILTER_EN
    chk("gl_data", data, 8'hBB);
`else
    chk("gl_data", data, 8'hDD);
`endif
    chk("gl_busy", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
